// File: rtl/led_toggle_checker.sv
// rtl/led_toggle_checker.sv - LED toggle monitor: sync, count, measure half-period, lock/error FSM
module led_toggle_checker #(
    parameter int CNT_WIDTH  = 16,
    parameter int EXP_HALF   = 2 ** CNT_WIDTH,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 2,
    parameter int TOG_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   led_i,
    input  logic                   clr_i,
    output logic                   edge_o,
    output logic [TOG_WIDTH-1:0]   toggle_cnt_o,
    output logic [CNT_WIDTH+1:0]   half_period_o,
    output logic                   locked_o,
    output logic                   err_o
);

    localparam int CW   = CNT_WIDTH + 2;
    localparam int GW   = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    // Lower bound clamps at zero so a tolerance wider than the period stays meaningful
    localparam int LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
    localparam int HI_I = EXP_HALF + TOL;
    localparam int TO_I = EXP_HALF + TOL + 1;

    localparam logic [CW-1:0] LO_V  = CW'(LO_I);
    localparam logic [CW-1:0] HI_V  = CW'(HI_I);
    localparam logic [CW-1:0] TO_V  = CW'(TO_I);
    localparam logic [CW-1:0] SAT_V = {CW{1'b1}};
    localparam logic [GW-1:0] LC_V  = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic                   edge_q, edge_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          hp_q, hp_d;
    logic [TOG_WIDTH-1:0]   tog_q, tog_d;
    logic [GW-1:0]          good_q, good_d;

    logic                   edge_det;
    logic                   in_range;
    logic                   timeout;
    logic                   good_evt;
    logic                   bad_evt;

    // Two-flop synchronizer plus a history flop; the synchronizer is never cleared by clr_i
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= led_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= S_IDLE;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
            hp_q    <= '0;
            tog_q   <= '0;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            tog_q   <= tog_d;
            good_q  <= good_d;
        end
    end

    // Interval classification, counter/measurement update and lock/error transitions
    always_comb begin
        edge_det = sync2_q ^ prev_q;
        in_range = (cnt_q >= LO_V) && (cnt_q <= HI_V);
        // The counter passes TO_V once per interval, so equality fires once
        timeout  = !edge_det && (cnt_q == TO_V);
        good_evt = edge_det && in_range;
        bad_evt  = edge_det ? !in_range : timeout;

        state_d = state_q;
        edge_d  = edge_det;
        cnt_d   = (cnt_q == SAT_V) ? cnt_q : cnt_q + CW'(1);
        hp_d    = hp_q;
        tog_d   = tog_q;
        good_d  = good_q;

        if (clr_i) begin
            state_d = S_IDLE;
            edge_d  = 1'b0;
            cnt_d   = '0;
            hp_d    = '0;
            tog_d   = '0;
            good_d  = '0;
        end else begin
            if (edge_det) begin
                tog_d = tog_q + TOG_WIDTH'(1);
                cnt_d = CW'(1);
                if (state_q != S_IDLE) begin
                    hp_d = cnt_q;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (edge_det) begin
                        state_d = S_TRACK;
                        good_d  = '0;
                    end
                end
                S_TRACK: begin
                    if (good_evt) begin
                        if (good_q + GW'(1) == LC_V) begin
                            state_d = S_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else if (bad_evt) begin
                        good_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (bad_evt) begin
                        state_d = S_ERROR;
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign edge_o        = edge_q;
    assign toggle_cnt_o  = tog_q;
    assign half_period_o = hp_q;
    assign locked_o      = (state_q == S_LOCKED);
    assign err_o         = (state_q == S_ERROR);

endmodule

// File: tb/tb_led_toggle_checker.sv
// tb/tb_led_toggle_checker.sv - self-checking bench for led_toggle_checker
`timescale 1ns/1ps
module tb_led_toggle_checker;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic led = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    // dut0: TOL=0, dut1: TOL=1, dut2: TOG_WIDTH=3
    logic        e0, e1, e2;
    logic [31:0] t0, t1;
    logic [2:0]  t2;
    logic [5:0]  h0, h1, h2;
    logic        l0, l1, l2;
    logic        r0, r1, r2;

    led_toggle_checker #(.CNT_WIDTH(4), .EXP_HALF(16), .TOL(0), .LOCK_COUNT(2), .TOG_WIDTH(32)) dut0 (
        .clk_i(clk), .arstn_i(arstn), .led_i(led), .clr_i(clr),
        .edge_o(e0), .toggle_cnt_o(t0), .half_period_o(h0), .locked_o(l0), .err_o(r0));
    led_toggle_checker #(.CNT_WIDTH(4), .EXP_HALF(16), .TOL(1), .LOCK_COUNT(2), .TOG_WIDTH(32)) dut1 (
        .clk_i(clk), .arstn_i(arstn), .led_i(led), .clr_i(clr),
        .edge_o(e1), .toggle_cnt_o(t1), .half_period_o(h1), .locked_o(l1), .err_o(r1));
    led_toggle_checker #(.CNT_WIDTH(4), .EXP_HALF(16), .TOL(0), .LOCK_COUNT(2), .TOG_WIDTH(3)) dut2 (
        .clk_i(clk), .arstn_i(arstn), .led_i(led), .clr_i(clr),
        .edge_o(e2), .toggle_cnt_o(t2), .half_period_o(h2), .locked_o(l2), .err_o(r2));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: LED history, plus per-instance interval bookkeeping
    localparam int M_IDLE = 0, M_TRACK = 1, M_LOCKED = 2, M_ERROR = 3;
    int     m_tol [3] = '{0, 1, 0};
    longint m_mod [3] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd8};
    bit     h1b, h2b, h3b;
    int     m_state [3];
    int     m_good [3];
    int     m_since [3];
    int     m_hp [3];
    longint m_tog [3];
    bit     m_edge [3];

    task automatic model_reset();
        h1b = 0; h2b = 0; h3b = 0;
        for (int i = 0; i < 3; i++) begin
            m_state[i] = M_IDLE; m_good[i] = 0; m_since[i] = 0;
            m_hp[i] = 0; m_tog[i] = 0; m_edge[i] = 0;
        end
    endtask

    task automatic model_step();
        bit ed;
        bit inr;
        bit bad;
        int dev;
        if (!arstn) begin
            model_reset();
            return;
        end
        ed = h2b ^ h3b;
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_state[i] = M_IDLE; m_good[i] = 0; m_since[i] = 0;
                m_hp[i] = 0; m_tog[i] = 0; m_edge[i] = 0;
            end else begin
                m_edge[i] = ed;
                if (ed) begin
                    m_tog[i] = (m_tog[i] + 1) % m_mod[i];
                    if (m_state[i] != M_IDLE) m_hp[i] = m_since[i];
                    dev = m_since[i] - 16;
                    inr = (dev <= m_tol[i]) && (dev >= -m_tol[i]);
                    bad = !inr;
                end else begin
                    inr = 0;
                    bad = (m_since[i] == 17 + m_tol[i]);
                end
                if (m_state[i] == M_IDLE) begin
                    if (ed) begin m_state[i] = M_TRACK; m_good[i] = 0; end
                end else if (m_state[i] == M_TRACK) begin
                    if (inr) begin
                        m_good[i]++;
                        if (m_good[i] == 2) m_state[i] = M_LOCKED;
                    end else if (bad) begin
                        m_good[i] = 0;
                    end
                end else if (m_state[i] == M_LOCKED) begin
                    if (bad) m_state[i] = M_ERROR;
                end
                if (ed) m_since[i] = 1;
                else if (m_since[i] < 63) m_since[i]++;
            end
        end
        h3b = h2b; h2b = h1b; h1b = led;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("edge0", {63'd0, e0}, {63'd0, m_edge[0]});
        chk("tog0",  {32'd0, t0}, m_tog[0]);
        chk("hp0",   {58'd0, h0}, 64'(m_hp[0]));
        chk("lock0", {63'd0, l0}, {63'd0, m_state[0] == M_LOCKED});
        chk("err0",  {63'd0, r0}, {63'd0, m_state[0] == M_ERROR});
        chk("edge1", {63'd0, e1}, {63'd0, m_edge[1]});
        chk("tog1",  {32'd0, t1}, m_tog[1]);
        chk("hp1",   {58'd0, h1}, 64'(m_hp[1]));
        chk("lock1", {63'd0, l1}, {63'd0, m_state[1] == M_LOCKED});
        chk("err1",  {63'd0, r1}, {63'd0, m_state[1] == M_ERROR});
        chk("tog2",  {61'd0, t2}, m_tog[2]);
        chk("lock2", {63'd0, l2}, {63'd0, m_state[2] == M_LOCKED});
        chk("err2",  {63'd0, r2}, {63'd0, m_state[2] == M_ERROR});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic toggle_wait(input int n);
        led = ~led;
        repeat (n) tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #1;
        model_reset();
        check_all();
        chk("reset_tog0", {32'd0, t0}, 64'd0);
        chk("reset_err0", {63'd0, r0}, 64'd0);
        tick();
        tick();
        arstn = 1'b1;

        // Clean blinker: lock one cycle after the third edge
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                led = ~led;
                tick(); tick();
                chk("prelock0", {63'd0, l0}, 64'd0);
                tick();
                chk("lock_at3", {63'd0, l0}, 64'd1);
                chk("tog_at3",  {32'd0, t0}, 64'd3);
                chk("hp_at3",   {58'd0, h0}, 64'd16);
                repeat (13) tick();
            end else begin
                toggle_wait(16);
            end
        end
        chk("clean_tog0", {32'd0, t0}, 64'd20);
        chk("clean_err0", {63'd0, r0}, 64'd0);
        chk("clean_tog2", {61'd0, t2}, 64'd4);

        // Bad 15-cycle interval while locked
        toggle_wait(15);
        led = ~led;
        tick(); tick(); tick();
        chk("bad_err0",  {63'd0, r0}, 64'd1);
        chk("bad_lock0", {63'd0, l0}, 64'd0);
        chk("bad_hp0",   {58'd0, h0}, 64'd15);
        chk("bad_lock1", {63'd0, l1}, 64'd1);
        repeat (13) tick();
        for (int i = 0; i < 10; i++) toggle_wait(16);
        chk("sticky_err0", {63'd0, r0}, 64'd1);

        // Timeout after lock, then clear and re-lock
        pulse_clr();
        chk("clr_tog0",  {32'd0, t0}, 64'd0);
        chk("clr_hp0",   {58'd0, h0}, 64'd0);
        chk("clr_err0",  {63'd0, r0}, 64'd0);
        chk("clr_edge0", {63'd0, e0}, 64'd0);
        for (int i = 0; i < 3; i++) toggle_wait(16);
        chk("relock0", {63'd0, l0}, 64'd1);
        repeat (10) tick();
        chk("tmo_err0", {63'd0, r0}, 64'd1);
        pulse_clr();
        for (int i = 0; i < 3; i++) toggle_wait(16);
        chk("relock_after_clr", {63'd0, l0}, 64'd1);

        // Tolerance window on dut1
        pulse_clr();
        toggle_wait(15);
        toggle_wait(17);
        toggle_wait(16);
        toggle_wait(18);
        chk("tol_lock1", {63'd0, l1}, 64'd1);
        chk("tol_err1",  {63'd0, r1}, 64'd0);
        toggle_wait(10);
        chk("tol18_err1", {63'd0, r1}, 64'd1);

        // Async reset mid-track
        pulse_clr();
        toggle_wait(16);
        toggle_wait(16);
        arstn = 1'b0;
        #1;
        model_reset();
        chk("arst_tog0", {32'd0, t0}, 64'd0);
        check_all();
        repeat (3) tick();
        arstn = 1'b1;
        for (int i = 0; i < 4; i++) toggle_wait(16);

        // Wrap of the 3-bit toggle counter
        pulse_clr();
        for (int i = 0; i < 9; i++) toggle_wait(16);
        chk("wrap_tog2", {61'd0, t2}, 64'd1);

        // Randomized intervals, holds and clears
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) pulse_clr();
            if ($urandom_range(0, 19) == 0) repeat (20) tick();
            toggle_wait(int'($urandom_range(12, 20)));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
